pulse_seq_gen: RTL and testbench
================================

// Module: pulse_seq_gen
// PURPOSE
//  Upstream stimulus stage for the Main/FF capture stage. Emits bursts of single-cycle
//  pulses on I and the arr[1:0] request/follow pair (arr[1] exactly one cycle after arr[0]).
//  Consumes O returned by the FF stage and counts cycles where O != I of the prior cycle.
//  Downstream assertions hold by construction: I |-> ##1 O, arr[0] |-> ##1 arr[1].
// PARAMETERS
//  PERIOD_W   8   width of period input; pulse spacing in cycles
//  BURST_W    4   width of burst_len input; pulses per burst
//  CNT_W      8   width of mismatch_cnt (saturating)
// PORTS
//  CLK           in   1         single clock, all state on posedge
//  RESET         in   1         synchronous, active-high
//  start         in   1         begin a burst; sampled only in IDLE
//  period        in   PERIOD_W  cycles between pulse starts; latched on start
//  burst_len     in   BURST_W   pulse count; latched on start
//  I             out  1         pulse to FF stage input
//  arr           out  2         [0]=request (with I), [1]=follow (next cycle)
//  O             in   1         FF stage output, expected == I delayed one cycle
//  busy          out  1         high from cycle after accepted start through DONE
//  done          out  1         one-cycle pulse at end of burst
//  pulse_cnt     out  BURST_W   pulses issued in current burst
//  mismatch_cnt  out  CNT_W     O mismatches since reset, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, checker disarmed. RESET mid-burst aborts, no done.
//  - All outputs registered. FSM states: IDLE, PULSE, FOLLOW, GAP, DONE.
//  - IDLE: start=1 -> latch per=max(period,2), len=burst_len, clear pulse_cnt.
//    len==0 -> DONE next cycle (no pulses); else PULSE next cycle (I high at t+1).
//  - PULSE (1 cyc): I=1, arr=2'b01, pulse_cnt++ on entry.
//  - FOLLOW (1 cyc): I=0, arr=2'b10. pulse_cnt==len -> DONE; per==2 -> PULSE; else GAP.
//  - GAP: per-2 cycles I=0 arr=0 via down-counter, then PULSE. Pulse starts exactly per apart.
//  - DONE (1 cyc): done=1, busy=1; -> IDLE. busy=0 in IDLE.
//  - start while not IDLE ignored; period/burst_len changes mid-burst ignored.
//  - Checker: I_d <= I every cycle; armed 1 cycle after RESET deasserts (FF has no reset).
//    When armed and O != I_d: mismatch_cnt++, saturates at 2**CNT_W-1; never cleared by start.
//  - Gap counter width PERIOD_W; no wrap since per>=2 and counts down to 0.
// CONFIGURATION
//  PULSE_SEQ_ASSERT_EN defined: inline SVA compiled in, clocked @(posedge CLK),
//   disabled iff RESET: arr[0] |-> ##1 arr[1]; I |-> arr[0]; arr[0] |-> ##1 !arr[0];
//   done |-> ##1 !busy; armed && I_d |-> O.
//  Not defined: no assertions, identical functional RTL.
// STRUCTURE
//  Package pulse_seq_pkg: state_t enum {IDLE,PULSE,FOLLOW,GAP,DONE}; MIN_PERIOD=2;
//   arr bit-index constants ARR_REQ=0, ARR_FOLLOW=1.
//  Sub-module pulse_seq_checker: I_d register, arm flag, saturating mismatch_cnt.
//  Top holds FSM, latched per/len, gap down-counter, pulse_cnt.
// TESTING
//  1 period=4,len=3,start@t0 -> I=1 at t1,t5,t9; arr[1] at t2,t6,t10; done at t11; pulse_cnt=3.
//  2 period=0 (clamped 2),len=2 -> I=1 at t1,t3; arr=01,10,01,10 back-to-back; done at t5.
//  3 len=0 -> no I pulses, done at t1, busy high only at t1.
//  4 O tied to I_d except forced 0 once -> mismatch_cnt=1; force 0 for 300 cyc -> saturates 255.
//  5 RESET asserted during GAP -> next cycle all outputs 0, IDLE, no done; new start works.
//  6 start pulsed while busy, period changed mid-burst -> timing unchanged from latched values.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Purpose: shared types and constants for the pulse sequence generator.
//   state_t    : FSM encoding (IDLE, PULSE, FOLLOW, GAP, DONE)
//   MIN_PERIOD : smallest legal pulse spacing; shorter requests are clamped up
//   ARR_REQ / ARR_FOLLOW : bit positions inside the arr[1:0] output
package pulse_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE  = 3'd1,
        FOLLOW = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int unsigned MIN_PERIOD = 2;
    localparam int unsigned ARR_REQ    = 0;
    localparam int unsigned ARR_FOLLOW = 1;

endpackage

// File: rtl/pulse_seq_checker.sv
// Purpose: watches the FF stage return path and counts cycles where O differs
//          from the I driven one cycle earlier.
// Ports:
//   CLK, RESET    : clock, synchronous active-high reset
//   I             : pulse sent to the FF stage this cycle
//   O             : FF stage output, expected to equal I of the prior cycle
//   mismatch_cnt  : saturating count of mismatches since reset
// Optional: PULSE_SEQ_ASSERT_EN compiles in an SVA check of the I -> O relation.
module pulse_seq_checker
    import pulse_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I,
    input  logic             O,
    output logic [CNT_W-1:0] mismatch_cnt
);

    logic i_dly;
    logic armed;

    // The FF stage has no reset, so its first post-reset output is not trusted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            i_dly        <= 1'b0;
            armed        <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            i_dly <= I;
            armed <= 1'b1;
            if (armed && (O != i_dly) && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PULSE_SEQ_ASSERT_EN
    a_i_to_o: assert property (@(posedge CLK) disable iff (RESET) (armed && i_dly) |-> O);
`else
`endif

endmodule

// File: rtl/pulse_seq_gen.sv
// Purpose: emits bursts of single-cycle pulses on I together with the
//          arr[1:0] request/follow pair, and counts FF stage mismatches.
// Ports:
//   CLK, RESET    : clock, synchronous active-high reset
//   start         : begin a burst (accepted only when idle)
//   period        : cycles between pulse starts, latched on start (min 2)
//   burst_len     : pulses per burst, latched on start
//   I             : pulse to FF stage
//   arr           : [0] request (with I), [1] follow (one cycle later)
//   O             : FF stage output
//   busy          : high from the cycle after an accepted start through DONE
//   done          : one-cycle pulse at end of burst
//   pulse_cnt     : pulses issued in the current burst
//   mismatch_cnt  : saturating O mismatch count since reset
// Optional: PULSE_SEQ_ASSERT_EN compiles in protocol SVA checks.
module pulse_seq_gen
    import pulse_seq_pkg::*;
#(
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned BURST_W  = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    input  logic [BURST_W-1:0]  burst_len,
    output logic                I,
    output logic [1:0]          arr,
    input  logic                O,
    output logic                busy,
    output logic                done,
    output logic [BURST_W-1:0]  pulse_cnt,
    output logic [CNT_W-1:0]    mismatch_cnt
);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [BURST_W-1:0]  len_q, len_d;
    logic [PERIOD_W-1:0] gap_q, gap_d;
    logic [BURST_W-1:0]  pcnt_d;
    logic                i_nxt, busy_nxt, done_nxt;
    logic [1:0]          arr_nxt;

    // Next-state and next-output logic; outputs are registered from state_d.
    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        len_d    = len_q;
        gap_d    = gap_q;
        pcnt_d   = pulse_cnt;
        i_nxt    = 1'b0;
        arr_nxt  = 2'b00;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    per_d   = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
                    len_d   = burst_len;
                    pcnt_d  = '0;
                    state_d = (burst_len == '0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                state_d = FOLLOW;
            end
            FOLLOW: begin
                if (pulse_cnt == len_q) begin
                    state_d = DONE;
                end else if (per_q == PERIOD_W'(MIN_PERIOD)) begin
                    state_d = PULSE;
                end else begin
                    // GAP lasts per-2 cycles: load per-3 and exit on zero.
                    gap_d   = per_q - PERIOD_W'(MIN_PERIOD + 1);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = PULSE;
                end else begin
                    gap_d = gap_q - PERIOD_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == PULSE) begin
            pcnt_d = pcnt_d + BURST_W'(1);
        end

        i_nxt               = (state_d == PULSE);
        arr_nxt[ARR_REQ]    = (state_d == PULSE);
        arr_nxt[ARR_FOLLOW] = (state_d == FOLLOW);
        busy_nxt            = (state_d != IDLE);
        done_nxt            = (state_d == DONE);
    end

    // State, burst context and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            per_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            pulse_cnt <= '0;
            I         <= 1'b0;
            arr       <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            pulse_cnt <= pcnt_d;
            I         <= i_nxt;
            arr       <= arr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    pulse_seq_checker #(
        .CNT_W (CNT_W)
    ) u_checker (
        .CLK          (CLK),
        .RESET        (RESET),
        .I            (I),
        .O            (O),
        .mismatch_cnt (mismatch_cnt)
    );

`ifdef PULSE_SEQ_ASSERT_EN
    a_req_follow: assert property (@(posedge CLK) disable iff (RESET) arr[ARR_REQ] |-> ##1 arr[ARR_FOLLOW]);
    a_i_req:      assert property (@(posedge CLK) disable iff (RESET) I |-> arr[ARR_REQ]);
    a_req_single: assert property (@(posedge CLK) disable iff (RESET) arr[ARR_REQ] |-> ##1 !arr[ARR_REQ]);
    a_done_idle:  assert property (@(posedge CLK) disable iff (RESET) done |-> ##1 !busy);
`else
`endif

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Purpose: directed self-checking bench for pulse_seq_gen. A behavioural FF
//          stage (O = I delayed one cycle, optionally inverted) closes the loop.
module tb_pulse_seq_gen;

    localparam int unsigned PERIOD_W = 8;
    localparam int unsigned BURST_W  = 4;
    localparam int unsigned CNT_W    = 8;

    logic                CLK = 1'b0;
    logic                RESET;
    logic                start;
    logic [PERIOD_W-1:0] period;
    logic [BURST_W-1:0]  burst_len;
    logic                I;
    logic [1:0]          arr;
    logic                O;
    logic                busy;
    logic                done;
    logic [BURST_W-1:0]  pulse_cnt;
    logic [CNT_W-1:0]    mismatch_cnt;

    logic ff_q = 1'b0;
    logic flip;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    // FF stage model: no reset, one-cycle delay, optional corruption.
    always @(posedge CLK) ff_q <= I;
    assign O = ff_q ^ flip;

    pulse_seq_gen #(
        .PERIOD_W (PERIOD_W),
        .BURST_W  (BURST_W),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .start        (start),
        .period       (period),
        .burst_len    (burst_len),
        .I            (I),
        .arr          (arr),
        .O            (O),
        .busy         (busy),
        .done         (done),
        .pulse_cnt    (pulse_cnt),
        .mismatch_cnt (mismatch_cnt)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {I, arr, busy, done} for each state letter.
    task automatic chk_state(input string tag, input byte c);
        logic [4:0] exp;
        case (c)
            "P":     exp = 5'b1_01_1_0;
            "F":     exp = 5'b0_10_1_0;
            "G":     exp = 5'b0_00_1_0;
            "D":     exp = 5'b0_00_1_1;
            default: exp = 5'b0_00_0_0;
        endcase
        chk(tag, 32'({I, arr, busy, done}), 32'(exp));
    endtask

    task automatic run_seq(input string tag, input string seq);
        for (int k = 0; k < seq.len(); k++) begin
            step();
            chk_state($sformatf("%s[%0d]", tag, k), seq[k]);
        end
    endtask

    // Launch a burst and follow the expected per-cycle state string from t1.
    task automatic burst(input string tag, input int per, input int len, input string seq);
        period    = PERIOD_W'(per);
        burst_len = BURST_W'(len);
        start     = 1'b1;
        for (int k = 0; k < seq.len(); k++) begin
            step();
            if (k == 0) start = 1'b0;
            chk_state($sformatf("%s[t%0d]", tag, k + 1), seq[k]);
        end
    endtask

    initial begin
        RESET     = 1'b1;
        start     = 1'b0;
        period    = '0;
        burst_len = '0;
        flip      = 1'b0;
        repeat (3) step();
        chk("reset_outputs", 32'({I, arr, busy, done, pulse_cnt, mismatch_cnt}), 32'd0);
        RESET = 1'b0;
        step();
        chk_state("post_reset_idle", "I");

        // period 4, three pulses: I at t1,t5,t9; done at t11
        burst("t1", 4, 3, "PFGGPFGGPFDI");
        chk("t1_pulse_cnt", 32'(pulse_cnt), 32'd3);
        chk("t1_no_mismatch", 32'(mismatch_cnt), 32'd0);

        // period 0 clamped to 2: back-to-back request/follow
        burst("t2", 0, 2, "PFPFDI");
        chk("t2_pulse_cnt", 32'(pulse_cnt), 32'd2);

        // zero-length burst: done at t1 only
        burst("t3", 7, 0, "DII");
        chk("t3_pulse_cnt", 32'(pulse_cnt), 32'd0);

        // start held and inputs changed mid-burst are ignored
        period    = 8'd6;
        burst_len = 4'd2;
        start     = 1'b1;
        step();
        period    = 8'd2;
        burst_len = 4'd9;
        chk_state("t6[t1]", "P");
        run_seq("t6_mid", "FGGGGPF");
        start = 1'b0;
        run_seq("t6_end", "DI");
        chk("t6_pulse_cnt", 32'(pulse_cnt), 32'd2);
        chk("t6_no_mismatch", 32'(mismatch_cnt), 32'd0);

        // single corrupted FF cycle
        flip = 1'b1;
        step();
        flip = 1'b0;
        chk("t4_single_mismatch", 32'(mismatch_cnt), 32'd1);
        step();
        chk("t4_single_hold", 32'(mismatch_cnt), 32'd1);

        // reset during GAP aborts the burst without done
        burst("t5", 5, 3, "PFG");
        RESET = 1'b1;
        step();
        chk("t5_reset_outputs", 32'({I, arr, busy, done, pulse_cnt, mismatch_cnt}), 32'd0);
        RESET = 1'b0;
        run_seq("t5_idle", "III");
        burst("t5_restart", 3, 1, "PFDI");
        chk("t5_restart_cnt", 32'(pulse_cnt), 32'd1);
        chk("t5_restart_no_mismatch", 32'(mismatch_cnt), 32'd0);

        // persistent corruption saturates the counter
        flip = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 100) chk("t4_count_100", 32'(mismatch_cnt), 32'd100);
        end
        flip = 1'b0;
        chk("t4_saturated", 32'(mismatch_cnt), 32'd255);
        step();
        chk("t4_saturated_hold", 32'(mismatch_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
